// File: rtl/branch_predictor_sat.sv
// PC-indexed saturating-counter branch predictor.
// Bimodal or gshare indexing with speculative GHR and EX-side repair.
module branch_predictor_sat #(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 4,
  parameter int CTR_BITS   = 2,
  parameter int GHR_BITS   = 4,
  parameter int MODE       = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_valid,
  input  logic [PC_WIDTH-1:0] if_pc,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                branchex,
  input  logic [PC_WIDTH-1:0] ex_pc,
  input  logic [GHR_BITS-1:0] ex_ghr,
  input  logic                ex_pred,
  input  logic                outcome,
  output logic                mispredict,
  output logic [31:0]         branch_count,
  output logic [31:0]         miss_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT =
    CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  if (INDEX_BITS < 1 || PC_WIDTH < INDEX_BITS + 2) begin : g_bad_index
    $error("INDEX_BITS must be >=1 and fit in PC_WIDTH-2");
  end
  if (GHR_BITS < 1 || GHR_BITS > INDEX_BITS) begin : g_bad_ghr
    $error("GHR_BITS must be in 1..INDEX_BITS");
  end
  if (CTR_BITS < 1) begin : g_bad_ctr
    $error("CTR_BITS must be >=1");
  end

  function automatic logic [INDEX_BITS-1:0] idx_f(
    input logic [PC_WIDTH-1:0] pc,
    input logic [GHR_BITS-1:0] g
  );
    logic [INDEX_BITS-1:0] gx;
    gx = (MODE != 0) ? INDEX_BITS'(g) : '0;
    return pc[INDEX_BITS+1:2] ^ gx;
  endfunction

  // Works for GHR_BITS == 1 where a [GHR_BITS-2:0] slice would not exist.
  function automatic logic [GHR_BITS-1:0] shift_f(
    input logic [GHR_BITS-1:0] g,
    input logic                b
  );
    logic [GHR_BITS:0] t;
    t = {g, b};
    return t[GHR_BITS-1:0];
  endfunction

  logic [CTR_BITS-1:0]   ctr [ENTRIES];
  logic [GHR_BITS-1:0]   ghr;
  logic [INDEX_BITS-1:0] lk_idx;
  logic [INDEX_BITS-1:0] tr_idx;
  logic                  lk_bit;
  logic                  miss;
  logic                  unused_pc;

  assign lk_idx    = idx_f(if_pc, ghr);
  assign tr_idx    = idx_f(ex_pc, ex_ghr);
  assign lk_bit    = ctr[lk_idx][CTR_BITS-1];
  assign miss      = branchex && (ex_pred != outcome);
  assign unused_pc = ^{if_pc, ex_pc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i] <= CTR_INIT;
      end
    end else if (branchex) begin
      if (outcome && ctr[tr_idx] != CTR_MAX) begin
        ctr[tr_idx] <= ctr[tr_idx] + 1'b1;
      end else if (!outcome && ctr[tr_idx] != '0) begin
        ctr[tr_idx] <= ctr[tr_idx] - 1'b1;
      end
    end
  end

  // Repair from EX outranks the speculative fetch-side shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr <= '0;
    end else if (miss) begin
      ghr <= shift_f(ex_ghr, outcome);
    end else if (if_valid) begin
      ghr <= shift_f(ghr, lk_bit);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_ghr   <= '0;
    end else begin
      pred_valid <= if_valid;
      if (if_valid) begin
        pred_taken <= lk_bit;
        pred_ghr   <= ghr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict   <= 1'b0;
      branch_count <= '0;
      miss_count   <= '0;
    end else begin
      mispredict <= miss;
      if (branchex && branch_count != '1) begin
        branch_count <= branch_count + 32'd1;
      end
      if (miss && miss_count != '1) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_sat.sv
// Directed bench for branch_predictor_sat.
// Bimodal and gshare instances share one stimulus stream.
module tb_branch_predictor_sat;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_pc = '0;
  logic        branchex = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [3:0]  ex_ghr = '0;
  logic        ex_pred = 1'b0;
  logic        outcome = 1'b0;

  logic        b_pv, b_pt, b_mp;
  logic [3:0]  b_pg;
  logic [31:0] b_bc, b_mc;
  logic        g_pv, g_pt, g_mp;
  logic [3:0]  g_pg;
  logic [31:0] g_bc, g_mc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predictor_sat #(.MODE(0)) u_bim (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_pc(if_pc),
    .pred_valid(b_pv), .pred_taken(b_pt), .pred_ghr(b_pg),
    .branchex(branchex), .ex_pc(ex_pc), .ex_ghr(ex_ghr),
    .ex_pred(ex_pred), .outcome(outcome),
    .mispredict(b_mp), .branch_count(b_bc), .miss_count(b_mc)
  );

  branch_predictor_sat #(.MODE(1)) u_gsh (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_pc(if_pc),
    .pred_valid(g_pv), .pred_taken(g_pt), .pred_ghr(g_pg),
    .branchex(branchex), .ex_pc(ex_pc), .ex_ghr(ex_ghr),
    .ex_pred(ex_pred), .outcome(outcome),
    .mispredict(g_mp), .branch_count(g_bc), .miss_count(g_mc)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic train(input logic [31:0] pc,
                       input logic p,
                       input logic o,
                       input logic [3:0] g);
    ex_pc = pc;
    ex_pred = p;
    outcome = o;
    ex_ghr = g;
    branchex = 1'b1;
    tick();
    branchex = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    if_pc = pc;
    if_valid = 1'b1;
    tick();
    if_valid = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_pv", 32'(b_pv), 0);
    chk("rst_pt", 32'(b_pt), 0);
    chk("rst_mp", 32'(b_mp), 0);
    chk("rst_bc", b_bc, 0);
    chk("rst_pg", 32'(g_pg), 0);
    rst_n = 1'b1;
    tick();

    // T1: build state, then reset mid-stream
    train(32'h30, 1'b1, 1'b1, 4'h0);
    train(32'h30, 1'b1, 1'b1, 4'h0);
    chk("pre_bc", b_bc, 2);
    look(32'h30);
    chk("pre_pv", 32'(b_pv), 1);
    chk("pre_pt", 32'(b_pt), 1);
    if_pc = 32'h30;
    if_valid = 1'b1;
    ex_pc = 32'h30;
    ex_pred = 1'b1;
    outcome = 1'b0;
    branchex = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_pv", 32'(b_pv), 0);
    chk("mid_pt", 32'(b_pt), 0);
    chk("mid_mp", 32'(b_mp), 0);
    chk("mid_bc", b_bc, 0);
    chk("mid_mc", b_mc, 0);
    if_valid = 1'b0;
    branchex = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    look(32'h30);
    chk("rel_pv", 32'(b_pv), 1);
    chk("rel_pt", 32'(b_pt), 0);
    chk("rel_bc", b_bc, 0);

    // T2: saturate high, then step down
    repeat (3) train(32'h10, 1'b1, 1'b1, 4'h0);
    look(32'h10);
    chk("sat_t3", 32'(b_pt), 1);
    tick();
    chk("hold_pv", 32'(b_pv), 0);
    chk("hold_pt", 32'(b_pt), 1);
    train(32'h10, 1'b0, 1'b0, 4'h0);
    look(32'h10);
    chk("sat_d1", 32'(b_pt), 1);
    train(32'h10, 1'b0, 1'b0, 4'h0);
    look(32'h10);
    chk("sat_d2", 32'(b_pt), 0);

    // T3: floor, no underflow wrap
    repeat (5) train(32'h20, 1'b0, 1'b0, 4'h0);
    train(32'h20, 1'b1, 1'b1, 4'h0);
    look(32'h20);
    chk("floor_u1", 32'(b_pt), 0);
    train(32'h20, 1'b1, 1'b1, 4'h0);
    look(32'h20);
    chk("floor_u2", 32'(b_pt), 1);

    // T4: aliasing into idx 1
    repeat (2) train(32'h04, 1'b1, 1'b1, 4'h0);
    look(32'h44);
    chk("alias_44", 32'(b_pt), 1);
    look(32'h08);
    chk("alias_08", 32'(b_pt), 0);

    // Mispredict pulse and counters
    train(32'h50, 1'b1, 1'b0, 4'h0);
    chk("mp_pulse", 32'(b_mp), 1);
    chk("mp_mc", b_mc, 1);
    chk("mp_bc", b_bc, 15);
    tick();
    chk("mp_drop", 32'(b_mp), 0);

    // T5: gshare repair
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    look(32'h08);
    chk("gs_pt0", 32'(g_pt), 0);
    chk("gs_pg0", 32'(g_pg), 0);
    if_pc = 32'h0C;
    if_valid = 1'b1;
    ex_pc = 32'h08;
    ex_ghr = 4'h0;
    ex_pred = 1'b0;
    outcome = 1'b1;
    branchex = 1'b1;
    tick();
    if_valid = 1'b0;
    branchex = 1'b0;
    chk("gs_mp", 32'(g_mp), 1);
    chk("gs_mc", g_mc, 1);
    chk("gs_pg1", 32'(g_pg), 0);
    look(32'h00);
    chk("gs_repair", 32'(g_pg), 1);
    chk("gs_mp_drop", 32'(g_mp), 0);

    // T6: same-edge lookup and train of idx 3
    if_pc = 32'h0C;
    if_valid = 1'b1;
    ex_pc = 32'h0C;
    ex_ghr = 4'h0;
    ex_pred = 1'b1;
    outcome = 1'b1;
    branchex = 1'b1;
    tick();
    if_valid = 1'b0;
    branchex = 1'b0;
    chk("col_old", 32'(b_pt), 0);
    chk("col_mp", 32'(b_mp), 0);
    look(32'h0C);
    chk("col_new", 32'(b_pt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
